// File: rtl/sram_requester.sv
// Initiator side of the single-port SRAM handshake.
// One outstanding access, bus turnaround on release, response timeout.
module sram_requester #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 14,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    inout  wire  [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_resp
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  accept;
    logic                  timeout_hit;

    // DONE also accepts, so a new access can start every third cycle.
    assign req_ready = ((state == IDLE) || (state == DONE)) && !mem_resp;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != IDLE);

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CW'(LAST));

    assign mem_data = mem_we ? wdata : {DATA_WIDTH{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            wdata     <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    if (accept) begin
                        mem_we   <= req_we;
                        mem_re   <= !req_we;
                        mem_addr <= req_addr;
                        wdata    <= req_wdata;
                        cnt      <= '0;
                        state    <= ACCESS;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    if (mem_resp) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        if (mem_re) begin
                            rsp_rdata <= mem_data;
                        end
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_requester.sv
// Bench for sram_requester: directed corner sequences, a vector table
// and a random mix scored against a word-level memory model.
module tb_sram_requester;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [13:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mem_re;
    logic        mem_we;
    logic [13:0] mem_addr;
    wire  [15:0] mem_data;
    logic        mem_resp;

    logic        mute;
    logic        inject;
    logic [15:0] rd_data;
    logic [15:0] mem [16];
    logic [15:0] ref_mem [16];
    logic [15:0] cur_wdata;
    int          cyc;
    int          total;
    int          passed;

    typedef struct {
        bit          we;
        bit          err;
        logic [15:0] rdata;
    } rsp_t;

    typedef struct {
        bit          we;
        logic [13:0] addr;
        logic [15:0] wdata;
        bit          mute;
        bit          exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    rsp_t exp_q[$];
    vec_t vecs[8];

    sram_requester #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(14),
        .TIMEOUT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .busy(busy),
        .mem_re(mem_re),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: answers one cycle after it sees an enable, unless muted.
    always @(posedge clk) begin
        mem_resp <= 1'b0;
        if (reset) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (inject) begin
            mem_resp <= 1'b1;
        end else if (!mute && (mem_re || mem_we) && !mem_resp) begin
            mem_resp <= 1'b1;
            if (mem_we) mem[mem_addr[3:0]] <= mem_data;
            else rd_data <= mem[mem_addr[3:0]];
        end
    end

    assign mem_data = (mem_re && mem_resp) ? rd_data : 16'bz;

    task automatic check(input bit ok, input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic monitor();
        rsp_t e;
        forever begin
            @(negedge clk);
            if (mem_re || mem_we)
                check(!(mem_re && mem_we), "re_we_excl",
                      {mem_re, mem_we}, 0);
            if (mem_we)
                check(mem_data == cur_wdata, "wdata_drive",
                      mem_data, cur_wdata);
            if (mem_re)
                check(!$isunknown(mem_data), "rd_bus_x", mem_data, 0);
            if (!rsp_valid && rsp_err)
                check(0, "err_no_valid", rsp_err, 0);
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check(0, "spurious_rsp", rsp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(rsp_err == e.err, "rsp_err", rsp_err, e.err);
                    if (!e.we || e.err)
                        check(rsp_rdata == e.rdata, "rsp_rdata",
                              rsp_rdata, e.rdata);
                end
            end
        end
    endtask

    task automatic issue(input bit we, input logic [13:0] a,
                         input logic [15:0] d, input bit m,
                         input bit eerr, input logic [15:0] erd,
                         input bit track,
                         output int wt, output int acc);
        rsp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        wt = 0;
        while (!req_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        acc = cyc;
        if (!req_ready) begin
            check(0, "accept_wait", wt, 50);
            req_valid = 1'b0;
            return;
        end
        mute      = m;
        cur_wdata = d;
        if (track) begin
            e.we = we;
            e.err = eerr;
            e.rdata = erd;
            exp_q.push_back(e);
        end
        if (we && !m) ref_mem[a[3:0]] = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int en);
        lat = 0;
        en  = 0;
        do begin
            @(negedge clk);
            lat++;
            if (mem_re || mem_we) en++;
        end while (!rsp_valid && lat < 40);
        if (!rsp_valid) check(0, "rsp_wait", lat, 40);
    endtask

    initial begin
        int wt;
        int acc;
        int lat;
        int en;
        int acc_t[4];
        bit rw;
        bit rm;
        logic [13:0] ra;
        logic [15:0] rd;

        total = 0;
        passed = 0;
        cyc = 0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        mute = 1'b0;
        inject = 1'b0;
        cur_wdata = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        vecs[0] = '{1'b1, 14'h7, 16'h1234, 1'b0, 1'b0, 16'h0};
        vecs[1] = '{1'b0, 14'h7, 16'h0,    1'b0, 1'b0, 16'h1234};
        vecs[2] = '{1'b1, 14'h8, 16'h00FF, 1'b0, 1'b0, 16'h0};
        vecs[3] = '{1'b0, 14'h8, 16'h0,    1'b0, 1'b0, 16'h00FF};
        vecs[4] = '{1'b0, 14'h9, 16'h0,    1'b1, 1'b1, 16'h0};
        vecs[5] = '{1'b1, 14'h7, 16'hCAFE, 1'b0, 1'b0, 16'h0};
        vecs[6] = '{1'b0, 14'h7, 16'h0,    1'b0, 1'b0, 16'hCAFE};
        vecs[7] = '{1'b0, 14'h5, 16'h0,    1'b0, 1'b0, 16'hBEEF};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check(req_ready == 1'b1, "rst_ready", req_ready, 1);
        check(busy == 1'b0, "rst_busy", busy, 0);
        check({mem_re, mem_we} == 2'b00, "rst_en", {mem_re, mem_we}, 0);
        check(mem_addr == '0, "rst_addr", mem_addr, 0);
        check(rsp_valid == 1'b0, "rst_rsp", rsp_valid, 0);
        check(rsp_rdata == '0, "rst_rdata", rsp_rdata, 0);

        fork
            monitor();
        join_none

        // Write then read back with latency and enable-window checks
        issue(1, 14'h5, 16'hBEEF, 0, 0, 16'h0, 1, wt, acc);
        wait_rsp(lat, en);
        check(en == 2, "wr_we_cycles", en, 2);
        check(lat == 3, "wr_latency", lat, 3);
        issue(0, 14'h5, 16'h0, 0, 0, 16'hBEEF, 1, wt, acc);
        wait_rsp(lat, en);
        check(lat == 3, "rd_latency", lat, 3);
        check(rsp_rdata == 16'hBEEF, "rd_beef", rsp_rdata, 16'hBEEF);

        // Back-to-back reads of preloaded words
        for (int i = 0; i < 4; i++)
            issue(1, 14'(i), 16'(16'h1111 * (i + 1)), 0, 0, 16'h0, 1,
                  wt, acc);
        for (int i = 0; i < 4; i++) begin
            issue(0, 14'(i), 16'h0, 0, 0, 16'(16'h1111 * (i + 1)), 1,
                  wt, acc);
            acc_t[i] = acc;
        end
        for (int i = 1; i < 4; i++)
            check(acc_t[i] - acc_t[i-1] == 3, "b2b_spacing",
                  acc_t[i] - acc_t[i-1], 3);

        // Timeout followed by a late memory pulse
        issue(0, 14'h9, 16'h0, 1, 1, 16'h0, 1, wt, acc);
        wait_rsp(lat, en);
        check(lat == 5, "to_latency", lat, 5);
        check(en == 4, "to_access_cycles", en, 4);
        check(rsp_err == 1'b1, "to_err", rsp_err, 1);
        check({mem_re, mem_we} == 2'b00, "to_en_drop",
              {mem_re, mem_we}, 0);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_addr = 14'h5;
        check(busy == 1'b0, "to_idle", busy, 0);
        check(req_ready == 1'b0, "late_ready", req_ready, 0);
        issue(0, 14'h5, 16'h0, 0, 0, 16'hBEEF, 1, wt, acc);
        check(wt == 0, "late_accept_next", wt, 0);
        wait_rsp(lat, en);
        check(lat == 3, "late_rd_latency", lat, 3);

        // Vector table
        foreach (vecs[i]) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mute,
                  vecs[i].exp_err, vecs[i].exp_rdata, 1, wt, acc);
        end
        wait_rsp(lat, en);

        // Reset during a write access drops it silently
        issue(1, 14'h20, 16'h5A5A, 1, 0, 16'h0, 0, wt, acc);
        @(negedge clk);
        check(mem_we == 1'b1, "mid_we", mem_we, 1);
        check(busy == 1'b1, "mid_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check(mem_we == 1'b0, "rst_mid_we", mem_we, 0);
        check(busy == 1'b0, "rst_mid_busy", busy, 0);
        check(rsp_valid == 1'b0, "rst_mid_rsp", rsp_valid, 0);
        check(mem_addr == '0, "rst_mid_addr", mem_addr, 0);
        check(rsp_rdata == '0, "rst_mid_rdata", rsp_rdata, 0);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;

        // Random mix against the word-level memory model
        for (int i = 0; i < 200; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 14'($urandom_range(0, 15));
            rd = 16'($urandom);
            rm = ($urandom_range(0, 9) == 0);
            if (rm)
                issue(rw, ra, rd, 1, 1, 16'h0, 1, wt, acc);
            else if (rw)
                issue(1, ra, rd, 0, 0, 16'h0, 1, wt, acc);
            else
                issue(0, ra, rd, 0, 0, ref_mem[ra[3:0]], 1, wt, acc);
        end

        wt = 0;
        while (exp_q.size() != 0 && wt < 100) begin
            @(negedge clk);
            wt++;
        end
        check(exp_q.size() == 0, "drain", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
